// File: rtl/cue_ball_motion.sv
// Cue ball motion: latches a cue hit, steps the ball once per video frame along an
// 8-way direction class, reflects at the cushions and decays speed under friction.
module cue_ball_motion #(
  parameter int TABLE_LEFT      = 64,
  parameter int TABLE_RIGHT     = 960,
  parameter int TABLE_TOP       = 64,
  parameter int TABLE_BOTTOM    = 704,
  parameter int BALL_R          = 8,
  parameter int START_X         = 320,
  parameter int START_Y         = 384,
  parameter int FRICTION_FRAMES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               cue_hit,
  input  logic signed [9:0]  pixel_speed,
  input  logic signed [10:0] x_diff,
  input  logic signed [10:0] y_diff,
  output logic signed [10:0] ball_x,
  output logic signed [10:0] ball_y,
  output logic               moving,
  output logic               done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_MOVE} state_t;
  typedef enum logic [1:0] {DIR_X, DIR_Y, DIR_DIAG} dir_t;

  typedef struct packed {
    logic signed [10:0] pos;
    logic               neg;
  } axis_t;

  // Cushion limits expressed on the ball centre.
  localparam logic signed [11:0] X_MIN = 12'(TABLE_LEFT + BALL_R);
  localparam logic signed [11:0] X_MAX = 12'(TABLE_RIGHT - BALL_R);
  localparam logic signed [11:0] Y_MIN = 12'(TABLE_TOP + BALL_R);
  localparam logic signed [11:0] Y_MAX = 12'(TABLE_BOTTOM - BALL_R);
  localparam logic [15:0]        FRIC_MAX = 16'(FRICTION_FRAMES);

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d;
  logic signed [10:0] x_q, x_d, y_q, y_d;
  logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
  logic [9:0]         s_q, s_d;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [15:0]        fric_q, fric_d;
  logic               moving_q, moving_d, done_q, done_d;

  logic [11:0] adx_s, ady_s, mag_full_s, mag_diag_s, mag_x_s, mag_y_s;
  logic [15:0] fric_inc_s;
  logic        hit_ok_s;
  axis_t       ax_s, ay_s;

  function automatic logic [11:0] abs12(input logic signed [10:0] v);
    logic signed [11:0] w;
    w = {v[10], v};
    return v[10] ? 12'(-w) : 12'(w);
  endfunction

  // Step one axis in 12-bit signed arithmetic; a landing past a cushion clamps and reflects.
  function automatic axis_t move_axis(input logic signed [10:0] pos, input logic [11:0] mag,
                                      input logic neg, input logic signed [11:0] lo,
                                      input logic signed [11:0] hi);
    logic signed [11:0] np;
    axis_t r;
    if (neg) np = $signed({pos[10], pos}) - $signed(mag);
    else     np = $signed({pos[10], pos}) + $signed(mag);
    r.pos = np[10:0];
    r.neg = neg;
    if (np > hi) begin
      r.pos = hi[10:0];
      r.neg = 1'b1;
    end else if (np < lo) begin
      r.pos = lo[10:0];
      r.neg = 1'b0;
    end else begin
      r.neg = neg;
    end
    return r;
  endfunction

  assign adx_s      = abs12(dx_q);
  assign ady_s      = abs12(dy_q);
  assign mag_full_s = {2'b00, s_q};
  assign mag_diag_s = {2'b00, (s_q >> 1) + (s_q >> 2)};
  assign fric_inc_s = fric_q + 16'd1;
  assign hit_ok_s   = cue_hit && (pixel_speed > 10'sd0) &&
                      ((x_diff != 11'sd0) || (y_diff != 11'sd0));

  // Per-axis step magnitude from the latched direction class.
  always_comb begin
    mag_x_s = 12'd0;
    mag_y_s = 12'd0;
    case (dir_q)
      DIR_X:    mag_x_s = mag_full_s;
      DIR_Y:    mag_y_s = mag_full_s;
      DIR_DIAG: begin
        mag_x_s = mag_diag_s;
        mag_y_s = mag_diag_s;
      end
      default: begin
        mag_x_s = 12'd0;
        mag_y_s = 12'd0;
      end
    endcase
  end

  assign ax_s = move_axis(x_q, mag_x_s, sx_neg_q, X_MIN, X_MAX);
  assign ay_s = move_axis(y_q, mag_y_s, sy_neg_q, Y_MIN, Y_MAX);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    s_d      = s_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    fric_d   = fric_q;
    moving_d = moving_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit_ok_s) begin
          s_d      = pixel_speed[9:0];
          dx_d     = x_diff;
          dy_d     = y_diff;
          fric_d   = 16'd0;
          moving_d = 1'b1;
          state_d  = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        sx_neg_d = dx_q[10];
        sy_neg_d = dy_q[10];
        if ({1'b0, adx_s} >= {ady_s, 1'b0}) begin
          dir_d = DIR_X;
        end else if ({1'b0, ady_s} >= {adx_s, 1'b0}) begin
          dir_d = DIR_Y;
        end else begin
          dir_d = DIR_DIAG;
        end
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (frame_tick) begin
          x_d      = ax_s.pos;
          y_d      = ay_s.pos;
          sx_neg_d = ax_s.neg;
          sy_neg_d = ay_s.neg;
          // Friction applies after this tick's movement.
          if (fric_inc_s >= FRIC_MAX) begin
            fric_d = 16'd0;
            s_d    = s_q - 10'd1;
            if (s_q <= 10'd1) begin
              s_d      = 10'd0;
              state_d  = ST_IDLE;
              moving_d = 1'b0;
              done_d   = 1'b1;
            end else begin
              state_d = ST_MOVE;
            end
          end else begin
            fric_d = fric_inc_s;
          end
        end else begin
          state_d = ST_MOVE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        moving_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_X;
      x_q      <= 11'(START_X);
      y_q      <= 11'(START_Y);
      dx_q     <= 11'sd0;
      dy_q     <= 11'sd0;
      s_q      <= 10'd0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      fric_q   <= 16'd0;
      moving_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      s_q      <= s_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      fric_q   <= fric_d;
      moving_q <= moving_d;
      done_q   <= done_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign moving = moving_q;
  assign done   = done_q;

endmodule
